// File: rtl/mnist_pkg.sv
// Shared constants, types and the exact uint8 -> IEEE-754 single conversion
// used by the MNIST image path.
package mnist_pkg;

  localparam int BEAT_BITS    = 128;
  localparam int PIX_BITS     = 8;
  localparam int NUM_PIXELS   = 784;
  localparam int PIX_PER_BEAT = BEAT_BITS / PIX_BITS;
  localparam int NUM_BEATS    = NUM_PIXELS / PIX_PER_BEAT;
  localparam int BEAT_AW      = 6;
  localparam int PIX_IDX_W    = 10;
  localparam int SUB_W        = $clog2(PIX_PER_BEAT);

  typedef logic [PIX_BITS-1:0]  pix_t;
  typedef logic [BEAT_BITS-1:0] beat_t;
  typedef logic [31:0]          fp32_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_FULL,
    ST_STREAM
  } state_e;

  // Every uint8 is exactly representable: exponent from the leading one,
  // remaining bits left-aligned into the mantissa.
  function automatic fp32_t u8_to_fp32(input pix_t p);
    logic [2:0]  msb;
    logic [23:0] norm;
    fp32_t       f;
    msb = '0;
    f   = '0;
    for (int i = 0; i < PIX_BITS; i++) begin
      if (p[i]) msb = 3'(i);
    end
    norm = {p, 16'h0000} << (3'd7 - msb);
    if (p != '0) f = {1'b0, 8'd127 + {5'd0, msb}, norm[22:0]};
    return f;
  endfunction

  function automatic fp32_t uint_to_float(input pix_t v);
    return u8_to_fp32(v);
  endfunction

endpackage

// File: rtl/img_beat_ram.sv
// Simple dual-port beat buffer: one write port fed by accepted SDRAM beats,
// one synchronous read port with 1-cycle latency.
module img_beat_ram
  import mnist_pkg::*;
#(
  parameter int ADDR_W = BEAT_AW
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  beat_t             wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output beat_t             rd_data_o
);

  beat_t mem_q [2**ADDR_W];
  beat_t rd_data_q;

  // NOTE: the array and its read register carry no reset so the buffer maps
  // onto block RAM; contents are only meaningful after a completed fill.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/img_pixel_streamer.sv
// Captures one image as 128-bit beats into RAM, then replays it one pixel per
// consumer request as raw uint8 plus exact fp32, re-streamable without reload.
module img_pixel_streamer
  import mnist_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  load_start,
  input  beat_t beat_data,
  input  logic  beat_valid,
  output logic  beat_ready,
  output logic  load_done,
  input  logic  stream_start,
  input  logic  pix_next,
  output logic  pix_valid,
  output pix_t  pix_data,
  output fp32_t pix_fp,
  output logic  pix_last,
  output logic  busy
);

  localparam logic [BEAT_AW-1:0]   LAST_BEAT = BEAT_AW'(NUM_BEATS - 1);
  localparam logic [BEAT_AW-1:0]   BEAT_SAT  = BEAT_AW'(NUM_BEATS);
  localparam logic [PIX_IDX_W-1:0] LAST_PIX  = PIX_IDX_W'(NUM_PIXELS - 1);

  state_e                 state_q;
  logic [BEAT_AW-1:0]     beat_cnt_q;
  logic [PIX_IDX_W-1:0]   pix_idx_q, pix_idx_d;
  logic                   first_q;
  logic                   load_done_q, pix_valid_q, pix_last_q;
  pix_t                   pix_data_q;
  fp32_t                  pix_fp_q;

  logic                   beat_accept, stream_go, pix_adv;
  logic                   rd_en;
  logic [BEAT_AW-1:0]     rd_addr;
  beat_t                  rd_beat;
  pix_t                   pix_sel;
  logic [SUB_W+2:0]       byte_lsb;

  assign beat_ready  = (state_q == ST_FILL);
  assign beat_accept = beat_valid && beat_ready;
  assign busy        = (state_q == ST_FILL) || (state_q == ST_STREAM);
  assign stream_go   = (state_q == ST_FULL) && stream_start && !load_start;
  assign pix_adv     = (state_q == ST_STREAM) && !first_q && pix_valid_q &&
                       pix_next && !pix_last_q && !load_start;

  img_beat_ram #(.ADDR_W(BEAT_AW)) u_ram (
    .clk      (clk),
    .wr_en_i  (beat_accept),
    .wr_addr_i(beat_cnt_q),
    .wr_data_i(beat_data),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_beat)
  );

  // The RAM output holds the beat being replayed; the next beat is fetched in
  // the same cycle its predecessor's last byte is latched, so no bubble.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    pix_idx_d = first_q ? '0 : pix_idx_q + PIX_IDX_W'(1);
    byte_lsb  = {pix_idx_d[SUB_W-1:0], 3'b000};
    pix_sel   = rd_beat[byte_lsb +: PIX_BITS];
    rd_en     = 1'b0;
    rd_addr   = '0;
    if (stream_go) begin
      rd_en = 1'b1;
    end else if (pix_adv && (&pix_idx_d[SUB_W-1:0]) && (pix_idx_d != LAST_PIX)) begin
      rd_en   = 1'b1;
      rd_addr = pix_idx_d[PIX_IDX_W-1:SUB_W] + BEAT_AW'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      pix_idx_q   <= '0;
      first_q     <= 1'b0;
      load_done_q <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_last_q  <= 1'b0;
      pix_data_q  <= '0;
      pix_fp_q    <= '0;
    end else begin
      load_done_q <= 1'b0;
      if (load_start) begin
        state_q     <= ST_FILL;
        beat_cnt_q  <= '0;
        first_q     <= 1'b0;
        pix_valid_q <= 1'b0;
        pix_last_q  <= 1'b0;
        pix_data_q  <= '0;
        pix_fp_q    <= '0;
      end else begin
        case (state_q)
          ST_FILL: begin
            if (beat_accept) begin
              if (beat_cnt_q != BEAT_SAT) beat_cnt_q <= beat_cnt_q + BEAT_AW'(1);
              if (beat_cnt_q == LAST_BEAT) begin
                state_q     <= ST_FULL;
                load_done_q <= 1'b1;
              end
            end
          end
          ST_FULL: begin
            if (stream_start) begin
              state_q   <= ST_STREAM;
              pix_idx_q <= '0;
              first_q   <= 1'b1;
            end
          end
          ST_STREAM: begin
            first_q <= 1'b0;
            if (first_q || pix_adv) begin
              pix_idx_q   <= pix_idx_d;
              pix_valid_q <= 1'b1;
              pix_data_q  <= pix_sel;
              pix_fp_q    <= u8_to_fp32(pix_sel);
              pix_last_q  <= (pix_idx_d == LAST_PIX);
            end else if (pix_valid_q && pix_next && pix_last_q) begin
              state_q     <= ST_FULL;
              pix_valid_q <= 1'b0;
              pix_last_q  <= 1'b0;
              pix_data_q  <= '0;
              pix_fp_q    <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign load_done = load_done_q;
  assign pix_valid = pix_valid_q;
  assign pix_data  = pix_data_q;
  assign pix_fp    = pix_fp_q;
  assign pix_last  = pix_last_q;

endmodule

// File: tb/tb_img_pixel_streamer.sv
// Directed bench for img_pixel_streamer: ramp load/stream, fp32 values,
// random gaps, restart mid-stream and reset mid-load.
module tb_img_pixel_streamer;
  import mnist_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_start = 1'b0;
  beat_t       beat_data = '0;
  logic        beat_valid = 1'b0;
  logic        beat_ready;
  logic        load_done;
  logic        stream_start = 1'b0;
  logic        pix_next = 1'b0;
  logic        pix_valid;
  pix_t        pix_data;
  logic [31:0] pix_fp;
  logic        pix_last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  img_pixel_streamer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_start  (load_start),
    .beat_data   (beat_data),
    .beat_valid  (beat_valid),
    .beat_ready  (beat_ready),
    .load_done   (load_done),
    .stream_start(stream_start),
    .pix_next    (pix_next),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_fp      (pix_fp),
    .pix_last    (pix_last),
    .busy        (busy)
  );

  function automatic pix_t exp_pix(input int seed, input int i);
    return pix_t'((i + seed) & 255);
  endfunction

  function automatic beat_t make_beat(input int seed, input int k);
    beat_t b;
    b = '0;
    for (int j = 0; j < 16; j++) b[8*j +: 8] = exp_pix(seed, 16*k + j);
    return b;
  endfunction

  // Hand-computed fp32 encodings for a few pixel values.
  function automatic logic fp_known(input pix_t v, output logic [31:0] f);
    f = 32'h0;
    case (v)
      8'd0:    begin f = 32'h0000_0000; return 1'b1; end
      8'd1:    begin f = 32'h3F80_0000; return 1'b1; end
      8'd15:   begin f = 32'h4170_0000; return 1'b1; end
      8'd128:  begin f = 32'h4300_0000; return 1'b1; end
      8'd255:  begin f = 32'h437F_0000; return 1'b1; end
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_load(input int seed, input bit rnd, input bit issue_start);
    int   k, rdy_cycles, done_seen, cyc;
    logic v, rdy;
    if (issue_start) begin
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
    end
    k = 0; rdy_cycles = 0; done_seen = 0; cyc = 0;
    while (k < NUM_BEATS && cyc < 4000) begin
      rdy = beat_ready;
      if (rdy) rdy_cycles++;
      if (load_done) done_seen++;
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      beat_valid = v;
      beat_data  = v ? make_beat(seed, k) : {4{32'($urandom())}};
      @(negedge clk);
      cyc++;
      if (v && rdy) k++;
    end
    beat_valid = 1'b0;
    checks++;
    if (k != NUM_BEATS) begin
      errors++;
      $display("FAIL load_timeout: got %0d beats accepted, want %0d", k, NUM_BEATS);
    end
    checks++;
    if (load_done !== 1'b1 || beat_ready !== 1'b0 || done_seen != 0) begin
      errors++;
      $display("FAIL load_done_pulse: got done=%b ready=%b early=%0d, want 1 0 0",
               load_done, beat_ready, done_seen);
    end
    if (!rnd) begin
      checks++;
      if (rdy_cycles != NUM_BEATS) begin
        errors++;
        $display("FAIL ready_cycles: got %0d, want %0d", rdy_cycles, NUM_BEATS);
      end
    end
    @(negedge clk);
    checks++;
    if (load_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL load_done_single: got done=%b busy=%b, want 0 0", load_done, busy);
    end
  endtask

  task automatic do_stream(input int seed, input bit rnd, input int stop_at);
    int          i, cyc;
    logic        nx, known, held;
    logic [31:0] fpk, hold_fp;
    pix_t        e;
    stream_start = 1'b1;
    @(negedge clk);
    stream_start = 1'b0;
    checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stream_latency_c1: got valid=%b busy=%b, want 0 1", pix_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (pix_valid !== 1'b1) begin
      errors++;
      $display("FAIL stream_latency_c2: got valid=%b, want 1", pix_valid);
    end
    i = 0; cyc = 0; held = 1'b0; hold_fp = '0;
    while (i < NUM_PIXELS && cyc < 5000) begin
      if (pix_valid !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL stream_gap: got valid=%b at pixel %0d, want 1", pix_valid, i);
        pix_next = 1'b0;
      end else begin
        e = exp_pix(seed, i);
        checks++;
        if (pix_data !== e || pix_last !== (i == NUM_PIXELS - 1)) begin
          errors++;
          $display("FAIL pixel[%0d]: got data=%02h last=%b, want data=%02h last=%b",
                   i, pix_data, pix_last, e, (i == NUM_PIXELS - 1));
        end
        known = fp_known(e, fpk);
        if (known) begin
          checks++;
          if (pix_fp !== fpk) begin
            errors++;
            $display("FAIL pix_fp[%0d]: got %08h, want %08h", i, pix_fp, fpk);
          end
        end
        if (held) begin
          checks++;
          if (pix_fp !== hold_fp) begin
            errors++;
            $display("FAIL hold_fp[%0d]: got %08h, want %08h", i, pix_fp, hold_fp);
          end
        end
        if (i == stop_at) begin
          pix_next = 1'b0;
          return;
        end
        nx       = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        pix_next = nx;
        hold_fp  = pix_fp;
        held     = !nx;
        if (nx) i++;
      end
      @(negedge clk);
      cyc++;
    end
    pix_next = 1'b0;
    checks++;
    if (i != NUM_PIXELS) begin
      errors++;
      $display("FAIL stream_timeout: got %0d pixels, want %0d", i, NUM_PIXELS);
    end
    checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stream_end: got valid=%b busy=%b, want 0 0", pix_valid, busy);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({beat_ready, load_done, pix_valid, pix_last, busy} !== 5'b0 ||
        pix_data !== 8'h00 || pix_fp !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b done=%b val=%b last=%b busy=%b data=%02h fp=%08h, want all 0",
               beat_ready, load_done, pix_valid, pix_last, busy, pix_data, pix_fp);
    end
    reset_n = 1'b1;
    @(negedge clk);
    stream_start = 1'b1;
    @(negedge clk);
    stream_start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_stream_ignored: got valid=%b busy=%b, want 0 0", pix_valid, busy);
    end
  endtask

  task automatic test_load_ramp;
    do_load(0, 1'b0, 1'b1);
  endtask

  task automatic test_stream_full;
    do_stream(0, 1'b0, -1);
  endtask

  task automatic test_fp32;
    do_stream(0, 1'b0, -1);
  endtask

  task automatic test_random;
    do_load(0, 1'b1, 1'b1);
    do_stream(0, 1'b1, -1);
  endtask

  task automatic test_coincident_start;
    load_start   = 1'b1;
    stream_start = 1'b1;
    @(negedge clk);
    load_start   = 1'b0;
    stream_start = 1'b0;
    checks++;
    if (beat_ready !== 1'b1 || pix_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL coincident_start: got ready=%b valid=%b busy=%b, want 1 0 1",
               beat_ready, pix_valid, busy);
    end
    do_load(0, 1'b0, 1'b0);
  endtask

  task automatic test_restart_mid_stream;
    do_stream(0, 1'b0, 300);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    checks++;
    if (pix_valid !== 1'b0 || beat_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_mid_stream: got valid=%b ready=%b, want 0 1", pix_valid, beat_ready);
    end
    do_load(8'h5A, 1'b0, 1'b0);
    do_stream(8'h5A, 1'b0, -1);
  endtask

  task automatic test_reset_mid_load;
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      beat_valid = 1'b1;
      beat_data  = make_beat(0, k);
      @(negedge clk);
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({beat_ready, load_done, pix_valid, pix_last, busy} !== 5'b0 ||
        pix_data !== 8'h00 || pix_fp !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_load: got rdy=%b done=%b val=%b last=%b busy=%b data=%02h fp=%08h, want all 0",
               beat_ready, load_done, pix_valid, pix_last, busy, pix_data, pix_fp);
    end
    reset_n    = 1'b1;
    beat_valid = 1'b0;
    @(negedge clk);
    stream_start = 1'b1;
    @(negedge clk);
    stream_start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (pix_valid !== 1'b0 || busy !== 1'b0 || beat_ready !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle[%0d]: got valid=%b busy=%b ready=%b, want 0 0 0",
                 c, pix_valid, busy, beat_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_ramp();
    test_stream_full();
    test_fp32();
    test_random();
    test_coincident_start();
    test_restart_mid_stream();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
